// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard:
// RV32I opcodes, in-flight stage entry layout and decode results.
package hazard_scoreboard_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;

  localparam int REG_W = 5;

  // Forwarding select value meaning "read the register file".
  localparam int FWD_REGFILE = 0;

  typedef enum logic [3:0] {
    CLS_RTYPE,
    CLS_ITYPE,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_UPPER,
    CLS_NONE
  } inst_class_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             is_load;
  } stage_entry_t;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
    logic is_load;
  } decode_t;

endpackage

// File: rtl/hazard_scoreboard_decode.sv
// Opcode classifier: which source registers an instruction reads,
// whether it writes rd, and whether its result comes from memory.
module hazard_scoreboard_decode
  import hazard_scoreboard_pkg::*;
(
  input  logic [6:0] opcode,
  output decode_t    info
);

  inst_class_e inst_class;

  always_comb begin
    inst_class = CLS_NONE;
    case (opcode)
      OPC_ARI_RTYPE: inst_class = CLS_RTYPE;
      OPC_ARI_ITYPE: inst_class = CLS_ITYPE;
      OPC_LOAD:      inst_class = CLS_LOAD;
      OPC_STORE:     inst_class = CLS_STORE;
      OPC_BRANCH:    inst_class = CLS_BRANCH;
      OPC_JAL:       inst_class = CLS_JAL;
      OPC_JALR:      inst_class = CLS_JALR;
      OPC_LUI,
      OPC_AUIPC:     inst_class = CLS_UPPER;
      default:       inst_class = CLS_NONE;
    endcase
  end

  always_comb begin
    info = '0;
    case (inst_class)
      CLS_RTYPE:  info = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b1, is_load: 1'b0};
      CLS_ITYPE:  info = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1, is_load: 1'b0};
      CLS_LOAD:   info = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1, is_load: 1'b1};
      CLS_STORE:  info = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b0, is_load: 1'b0};
      CLS_BRANCH: info = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b0, is_load: 1'b0};
      CLS_JAL:    info = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b1, is_load: 1'b0};
      CLS_JALR:   info = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1, is_load: 1'b0};
      CLS_UPPER:  info = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b1, is_load: 1'b0};
      default:    info = '0;
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit: tracks destination registers of in-flight instructions and
// produces per-source forwarding selects plus a load-use stall request.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 2,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             issue_valid,
  input  logic [31:0]      issue_inst,
  input  logic             flush,
  output logic             stall,
  output logic [SEL_W-1:0] fwd_sel_rs1,
  output logic [SEL_W-1:0] fwd_sel_rs2,
  output logic [31:0]      stall_count
);

  stage_entry_t     entries [1:DEPTH];
  stage_entry_t     new_entry;
  decode_t          dec;
  logic [REG_W-1:0] rd;
  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic [1:0]       src_stall;
  logic [SEL_W-1:0] src_sel [2];
  logic             unused_inst_bits;

  assign rd  = issue_inst[11:7];
  assign rs1 = issue_inst[19:15];
  assign rs2 = issue_inst[24:20];
  assign unused_inst_bits = ^{issue_inst[31:25], issue_inst[14:12]};

  hazard_scoreboard_decode u_decode (
    .opcode (issue_inst[6:0]),
    .info   (dec)
  );

  for (genvar s = 0; s < 2; s++) begin : g_src
    logic [REG_W-1:0] src_reg;
    logic             src_used;
    logic [DEPTH:1]   match;
    int               hit_stage;
    logic             hit_load;

    assign src_reg  = (s == 0) ? rs1 : rs2;
    assign src_used = ((s == 0) ? dec.uses_rs1 : dec.uses_rs2) && (src_reg != '0);

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
      assign match[k] = entries[k].valid && (entries[k].rd == src_reg);
    end

    // Scan oldest to youngest so the youngest match is the one that sticks.
    always_comb begin
      hit_stage = 0;
      hit_load  = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
        if (match[k]) begin
          hit_stage = k;
          hit_load  = entries[k].is_load;
        end
      end
    end

    assign src_stall[s] = src_used && (hit_stage != 0) && hit_load && (hit_stage < LOAD_LAT);
    assign src_sel[s]   = (src_used && !src_stall[s]) ? SEL_W'(hit_stage) : SEL_W'(FWD_REGFILE);
  end

  assign stall       = issue_valid && !flush && (|src_stall);
  assign fwd_sel_rs1 = stall ? SEL_W'(FWD_REGFILE) : src_sel[0];
  assign fwd_sel_rs2 = stall ? SEL_W'(FWD_REGFILE) : src_sel[1];

  always_comb begin
    new_entry = '0;
    if (issue_valid && !stall && !flush && dec.writes_rd && (rd != '0)) begin
      new_entry.valid   = 1'b1;
      new_entry.rd      = rd;
      new_entry.is_load = dec.is_load;
    end
  end

  // Stage DEPTH falls off the end: it is writing the register file this cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 1; k <= DEPTH; k++) begin
        entries[k] <= '0;
      end
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        entries[k] <= entries[k-1];
      end
      entries[1] <= new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one DEPTH=2/LOAD_LAT=2 instance and
// one DEPTH=4/LOAD_LAT=3 instance, driven on negedge and checked before posedge.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        iv_a;
  logic [31:0] inst_a;
  logic        flush_a;
  logic        stall_a;
  logic [1:0]  sel1_a;
  logic [1:0]  sel2_a;
  logic [31:0] count_a;

  logic        iv_b;
  logic [31:0] inst_b;
  logic        flush_b;
  logic        stall_b;
  logic [2:0]  sel1_b;
  logic [2:0]  sel2_b;
  logic [31:0] count_b;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.DEPTH(2), .LOAD_LAT(2)) dut_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .issue_valid (iv_a),
    .issue_inst  (inst_a),
    .flush       (flush_a),
    .stall       (stall_a),
    .fwd_sel_rs1 (sel1_a),
    .fwd_sel_rs2 (sel2_a),
    .stall_count (count_a)
  );

  hazard_scoreboard #(.DEPTH(4), .LOAD_LAT(3)) dut_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .issue_valid (iv_b),
    .issue_inst  (inst_b),
    .flush       (flush_b),
    .stall       (stall_b),
    .fwd_sel_rs1 (sel1_b),
    .fwd_sel_rs2 (sel2_b),
    .stall_count (count_b)
  );

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd1, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction

  // Waits for the falling edge, drives one instance's inputs, lets combinational outputs settle.
  task automatic applyStimulus(input bit to_b, input logic valid, input logic [31:0] inst,
                               input logic fl);
    @(negedge clk);
    if (to_b) begin
      iv_b    = valid;
      inst_b  = inst;
      flush_b = fl;
    end else begin
      iv_a    = valid;
      inst_a  = inst;
      flush_a = fl;
    end
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    iv_a = 1'b0; inst_a = '0; flush_a = 1'b0;
    iv_b = 1'b0; inst_b = '0; flush_b = 1'b0;
    applyStimulus(0, 1'b0, 32'd0, 1'b0);
    applyStimulus(0, 1'b0, 32'd0, 1'b0);
    reset_n = 1'b1;

    $display("[TB] reset state");
    applyStimulus(0, 1'b0, 32'd0, 1'b0);
    checkOutput("reset_stall", {31'd0, stall_a}, 32'd0);
    checkOutput("reset_count", count_a, 32'd0);

    $display("[TB] ALU-to-ALU forwarding");
    applyStimulus(0, 1'b1, enc_r(7'h00, 5'd5, 5'd1, 5'd2), 1'b0);
    checkOutput("add1_sel1", {30'd0, sel1_a}, 32'd0);
    applyStimulus(0, 1'b1, enc_r(7'h00, 5'd6, 5'd5, 5'd1), 1'b0);
    checkOutput("dep_sel1", {30'd0, sel1_a}, 32'd1);
    checkOutput("dep_sel2", {30'd0, sel2_a}, 32'd0);
    checkOutput("dep_stall", {31'd0, stall_a}, 32'd0);

    $display("[TB] load-use, DEPTH=2 LOAD_LAT=2");
    applyStimulus(0, 1'b1, enc_lw(5'd5, 5'd1), 1'b0);
    checkOutput("lw_stall", {31'd0, stall_a}, 32'd0);
    applyStimulus(0, 1'b1, enc_r(7'h00, 5'd6, 5'd5, 5'd0), 1'b0);
    checkOutput("lu_stall", {31'd0, stall_a}, 32'd1);
    checkOutput("lu_sel1_stalled", {30'd0, sel1_a}, 32'd0);
    applyStimulus(0, 1'b1, enc_r(7'h00, 5'd6, 5'd5, 5'd0), 1'b0);
    checkOutput("lu_stall_released", {31'd0, stall_a}, 32'd0);
    checkOutput("lu_sel1_fwd", {30'd0, sel1_a}, 32'd2);
    checkOutput("lu_count", count_a, 32'd1);
    applyStimulus(0, 1'b0, 32'd0, 1'b0);
    applyStimulus(0, 1'b0, 32'd0, 1'b0);

    $display("[TB] youngest producer wins");
    applyStimulus(0, 1'b1, enc_addi(5'd5, 5'd1), 1'b0);
    applyStimulus(0, 1'b1, enc_addi(5'd5, 5'd1), 1'b0);
    applyStimulus(0, 1'b1, enc_r(7'h20, 5'd7, 5'd5, 5'd5), 1'b0);
    checkOutput("yw_sel1", {30'd0, sel1_a}, 32'd1);
    checkOutput("yw_sel2", {30'd0, sel2_a}, 32'd1);
    applyStimulus(0, 1'b0, 32'd0, 1'b0);
    applyStimulus(0, 1'b1, enc_r(7'h20, 5'd7, 5'd5, 5'd5), 1'b0);
    checkOutput("retired_sel1", {30'd0, sel1_a}, 32'd0);
    checkOutput("retired_sel2", {30'd0, sel2_a}, 32'd0);
    applyStimulus(0, 1'b0, 32'd0, 1'b0);
    applyStimulus(0, 1'b0, 32'd0, 1'b0);

    $display("[TB] x0 destination and store data forwarding");
    applyStimulus(0, 1'b1, enc_lw(5'd0, 5'd1), 1'b0);
    applyStimulus(0, 1'b1, enc_r(7'h00, 5'd6, 5'd0, 5'd0), 1'b0);
    checkOutput("x0_stall", {31'd0, stall_a}, 32'd0);
    checkOutput("x0_sel1", {30'd0, sel1_a}, 32'd0);
    checkOutput("x0_sel2", {30'd0, sel2_a}, 32'd0);
    applyStimulus(0, 1'b1, enc_r(7'h00, 5'd5, 5'd1, 5'd2), 1'b0);
    applyStimulus(0, 1'b1, enc_sw(5'd5, 5'd2), 1'b0);
    checkOutput("sw_sel2", {30'd0, sel2_a}, 32'd1);
    checkOutput("sw_sel1", {30'd0, sel1_a}, 32'd0);
    applyStimulus(0, 1'b0, 32'd0, 1'b0);
    applyStimulus(0, 1'b0, 32'd0, 1'b0);

    $display("[TB] flush overrides load-use stall");
    applyStimulus(0, 1'b1, enc_lw(5'd9, 5'd1), 1'b0);
    applyStimulus(0, 1'b1, enc_r(7'h00, 5'd10, 5'd9, 5'd9), 1'b1);
    checkOutput("flush_stall", {31'd0, stall_a}, 32'd0);
    checkOutput("flush_count", count_a, 32'd1);
    applyStimulus(0, 1'b1, enc_r(7'h00, 5'd11, 5'd10, 5'd0), 1'b0);
    checkOutput("flush_no_entry", {30'd0, sel1_a}, 32'd0);
    applyStimulus(0, 1'b0, 32'd0, 1'b0);
    applyStimulus(0, 1'b0, 32'd0, 1'b0);

    $display("[TB] reset during a stall");
    applyStimulus(0, 1'b1, enc_lw(5'd12, 5'd1), 1'b0);
    applyStimulus(0, 1'b1, enc_r(7'h00, 5'd13, 5'd12, 5'd0), 1'b0);
    checkOutput("pre_reset_stall", {31'd0, stall_a}, 32'd1);
    checkOutput("pre_reset_count", count_a, 32'd1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(0, 1'b1, enc_r(7'h00, 5'd13, 5'd12, 5'd0), 1'b0);
    checkOutput("post_reset_stall", {31'd0, stall_a}, 32'd0);
    checkOutput("post_reset_count", count_a, 32'd0);
    checkOutput("post_reset_sel1", {30'd0, sel1_a}, 32'd0);
    applyStimulus(0, 1'b0, 32'd0, 1'b0);

    $display("[TB] load-use, DEPTH=4 LOAD_LAT=3");
    applyStimulus(1, 1'b1, enc_lw(5'd5, 5'd1), 1'b0);
    checkOutput("b_lw_stall", {31'd0, stall_b}, 32'd0);
    applyStimulus(1, 1'b1, enc_r(7'h00, 5'd6, 5'd5, 5'd0), 1'b0);
    checkOutput("b_stall_1", {31'd0, stall_b}, 32'd1);
    applyStimulus(1, 1'b1, enc_r(7'h00, 5'd6, 5'd5, 5'd0), 1'b0);
    checkOutput("b_stall_2", {31'd0, stall_b}, 32'd1);
    applyStimulus(1, 1'b1, enc_r(7'h00, 5'd6, 5'd5, 5'd0), 1'b0);
    checkOutput("b_release_stall", {31'd0, stall_b}, 32'd0);
    checkOutput("b_sel1", {29'd0, sel1_b}, 32'd3);
    checkOutput("b_count", count_b, 32'd2);
    applyStimulus(1, 1'b1, enc_r(7'h00, 5'd7, 5'd6, 5'd5), 1'b0);
    checkOutput("b_alu_sel1", {29'd0, sel1_b}, 32'd1);
    checkOutput("b_load_sel2", {29'd0, sel2_b}, 32'd4);
    checkOutput("b_alu_stall", {31'd0, stall_b}, 32'd0);
    applyStimulus(1, 1'b0, 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
